// File: rtl/wb_mem_write_arbiter.sv
// Round-robin arbiter sharing one main-memory write port between NUM_REQ write-back
// sources; one transaction at a time, with an ack timeout and per-requester done/err pulses.
module wb_mem_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int COUNTER_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                 done,
    output logic [NUM_REQ-1:0]                 err,
    output logic                               busy,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               mem_w_en,
    output logic [ADDRESS_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]              mem_data,
    input  logic                               mem_ack,
    output logic                               timeout_sticky
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t                   state_q;
    logic [IDW-1:0]           rr_ptr_q;
    logic [IDW-1:0]           grant_q;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [NUM_REQ-1:0]       done_q;
    logic [NUM_REQ-1:0]       err_q;
    logic                     busy_q;
    logic                     w_en_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     sticky_q;

    logic                     win_valid_d;
    logic [IDW-1:0]           win_idx_d;
    int unsigned              cand_d;

    // First set request at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_valid_d = 1'b0;
        win_idx_d   = '0;
        cand_d      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_d = (32'(rr_ptr_q) + k) % 32'(NUM_REQ);
            if (!win_valid_d && req[cand_d]) begin
                win_valid_d = 1'b1;
                win_idx_d   = IDW'(cand_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            w_en_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid_d) begin
                        grant_q <= win_idx_d;
                        addr_q  <= req_addr[win_idx_d*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        data_q  <= req_data[win_idx_d*DATA_WIDTH +: DATA_WIDTH];
                        w_en_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Ack takes priority over an expiring counter.
                    if (mem_ack) begin
                        w_en_q          <= 1'b0;
                        done_q[grant_q] <= 1'b1;
                        state_q         <= DONE;
                    end else if (cnt_q == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        w_en_q         <= 1'b0;
                        err_q[grant_q] <= 1'b1;
                        sticky_q       <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q   <= '0;
                    err_q    <= '0;
                    addr_q   <= '0;
                    data_q   <= '0;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= IDW'((32'(grant_q) + 1) % 32'(NUM_REQ));
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    w_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done           = done_q;
    assign err            = err_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;
    assign mem_w_en       = w_en_q;
    assign mem_address    = addr_q;
    assign mem_data       = data_q;
    assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_wb_mem_write_arbiter.sv
// Directed bench for wb_mem_write_arbiter with a 5-cycle ack timeout; expected
// values are hand-computed from the arbitration and handshake rules.
module tb_wb_mem_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      done;
    logic [N-1:0]      err;
    logic              busy;
    logic [1:0]        grant_id;
    logic              mem_w_en;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_data;
    logic              mem_ack;
    logic              timeout_sticky;

    int checks = 0;
    int errors = 0;

    wb_mem_write_arbiter #(
        .NUM_REQ(N),
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .COUNTER_WIDTH(8),
        .TIMEOUT_CYCLES(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_addr(req_addr),
        .req_data(req_data),
        .done(done),
        .err(err),
        .busy(busy),
        .grant_id(grant_id),
        .mem_w_en(mem_w_en),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .mem_ack(mem_ack),
        .timeout_sticky(timeout_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Grant, hold for lat cycles with ack in the last one, then DONE and back to IDLE.
    task automatic do_xfer(input int id, input int lat, input logic [31:0] ea, input logic [31:0] ed);
        logic [N-1:0] oh;
        oh = 4'b0001 << id;
        tick();
        chk("grant_id", grant_id, id);
        chk("w_en_grant", mem_w_en, 1);
        chk("addr_grant", mem_address, ea);
        chk("data_grant", mem_data, ed);
        chk("busy_grant", busy, 1);
        for (int c = 1; c < lat; c++) begin
            tick();
            chk("w_en_wait", mem_w_en, 1);
            chk("data_wait", mem_data, ed);
        end
        mem_ack = 1'b1;
        tick();
        chk("done_pulse", done, oh);
        chk("err_none", err, 0);
        chk("w_en_drop", mem_w_en, 0);
        chk("busy_done", busy, 1);
        mem_ack = 1'b0;
        req[id] = 1'b0;
        tick();
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
        chk("addr_clear", mem_address, 0);
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        mem_ack  = 1'b0;

        tick();
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_w_en", mem_w_en, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_sticky", timeout_sticky, 0);
        reset = 1'b0;

        // Ack while idle must be ignored.
        mem_ack = 1'b1;
        tick();
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_done", done, 0);
        mem_ack = 1'b0;

        // Single request, ack in the third mem_w_en cycle.
        set_slot(0, 32'h0000_1000, 32'hDEAD_BEEF);
        req = 4'b0001;
        do_xfer(0, 3, 32'h0000_1000, 32'hDEAD_BEEF);

        // Round robin from rr_ptr=0: 0,1,3 then wrap back to 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_slot(i, 32'h2000 + 32'(i) * 32'h10, 32'h1111_0000 + 32'(i));
        req = 4'b1011;
        do_xfer(0, 2, 32'h2000, 32'h1111_0000);
        do_xfer(1, 1, 32'h2010, 32'h1111_0001);
        do_xfer(3, 2, 32'h2030, 32'h1111_0003);
        req[0] = 1'b1;
        do_xfer(0, 1, 32'h2000, 32'h1111_0000);

        // Timeout: no ack, mem_w_en high exactly 5 cycles.
        set_slot(2, 32'h3000, 32'hCAFE_0002);
        req = 4'b0100;
        tick();
        chk("to_grant", grant_id, 2);
        chk("to_w_en_1", mem_w_en, 1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("to_w_en_n", mem_w_en, 1);
            chk("to_err_early", err, 0);
        end
        tick();
        chk("to_w_en_drop", mem_w_en, 0);
        chk("to_err", err, 4'b0100);
        chk("to_done", done, 0);
        chk("to_sticky", timeout_sticky, 1);
        req = '0;
        tick();
        chk("to_err_clear", err, 0);
        chk("to_busy", busy, 0);
        tick();
        chk("to_sticky_hold", timeout_sticky, 1);

        // Ack on the final timeout cycle: done wins.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("race_sticky_rst", timeout_sticky, 0);
        set_slot(1, 32'h4000, 32'h0BAD_F00D);
        req = 4'b0010;
        do_xfer(1, 5, 32'h4000, 32'h0BAD_F00D);
        chk("race_sticky", timeout_sticky, 0);

        // Latched data stable while inputs change and req drops after grant.
        set_slot(1, 32'h5000, 32'hA5A5_A5A5);
        req = 4'b0010;
        tick();
        chk("stab_grant", grant_id, 1);
        chk("stab_data0", mem_data, 32'hA5A5_A5A5);
        set_slot(1, 32'h0, 32'h0);
        req = '0;
        tick();
        chk("stab_data1", mem_data, 32'hA5A5_A5A5);
        chk("stab_addr1", mem_address, 32'h5000);
        tick();
        chk("stab_data2", mem_data, 32'hA5A5_A5A5);
        chk("stab_w_en", mem_w_en, 1);
        mem_ack = 1'b1;
        tick();
        chk("stab_done", done, 4'b0010);
        chk("stab_data_done", mem_data, 32'hA5A5_A5A5);
        mem_ack = 1'b0;
        tick();
        chk("stab_data_clear", mem_data, 0);
        chk("stab_done_clear", done, 0);

        // Reset during WAIT_ACK; afterwards rr_ptr is 0 so 4'b1010 grants 1 (not 3).
        set_slot(2, 32'h6000, 32'h6666_6666);
        req = 4'b0100;
        tick();
        chk("mid_grant", grant_id, 2);
        chk("mid_w_en", mem_w_en, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_w_en_rst", mem_w_en, 0);
        chk("mid_busy_rst", busy, 0);
        chk("mid_done_rst", done, 0);
        chk("mid_err_rst", err, 0);
        chk("mid_grant_rst", grant_id, 0);
        chk("mid_addr_rst", mem_address, 0);
        chk("mid_data_rst", mem_data, 0);
        reset = 1'b0;
        req = '0;
        tick();
        chk("mid_done_after", done, 0);
        chk("mid_err_after", err, 0);
        set_slot(1, 32'h7000, 32'h7777_0001);
        set_slot(3, 32'h7300, 32'h7777_0003);
        req = 4'b1010;
        do_xfer(1, 1, 32'h7000, 32'h7777_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
